majority_bit_inserter: RTL and testbench
========================================

# majority_bit_inserter

Parametrised, pipelined successor to the combinational majority-bit inserter in the parity/shifter datapath. It takes a DATA_W-bit word over a valid/ready stream and computes one flag bit over **all** DATA_W bits. The flag is either zero-majority, one-majority, even parity or odd parity, selected per word. The block emits a DATA_W+1-bit word with the flag inserted at bit position INS_POS. It sits between the word source and the downstream shifter, with full-throughput back-pressure.

## Interface
- DATA_W, 7, input word width; legal range 2..64.
- INS_POS, 4, output bit index of the inserted flag; legal range 0..DATA_W. 0 places the flag at the LSB; DATA_W appends it at the MSB.
- CNT_W, 16, statistics counter width (used only with MBI_STATS_EN).
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DATA_W  input word.
- in_mode  in  2  flag mode for this word: 00 zero-majority, 01 one-majority, 10 even parity, 11 odd parity.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W+1  word with the flag inserted.
- out_flag  out  1  copy of the inserted flag.
- stat_clr  in  1  synchronous clear of the statistics counters (MBI_STATS_EN only).
- stat_words  out  CNT_W  count of words delivered (MBI_STATS_EN only).
- stat_flags  out  CNT_W  count of delivered words with flag = 1 (MBI_STATS_EN only).

## Operation
- **Stage 1 (S1)** captures in_data and in_mode, plus popcount `ones` (width $clog2(DATA_W+1)), when in_valid && in_ready.
- **Stage 2 (S2)** computes the flag from the S1 contents and registers out_data and out_flag.
  - zeros = DATA_W − ones.
  - Mode 00: flag = (zeros > ones).
  - Mode 01: flag = (ones > zeros).
  - Mode 10: flag = ones[0], so the total number of ones becomes even.
  - Mode 11: flag = ~ones[0].
  - A tie (even DATA_W only) gives flag = 0 in modes 00 and 01.
- **Output word:** out_data = {in_data[DATA_W-1:INS_POS], flag, in_data[INS_POS-1:0]}. Empty slices are omitted at INS_POS = 0 or INS_POS = DATA_W.
- **Pipeline control:** per-stage valid bits; a stage advances when its successor is empty or is itself advancing.
  - in_ready = !s1_valid || !s2_valid || out_ready. This is combinational, with no combinational path from in_valid.
  - No words are dropped, duplicated or reordered.
- **Stall:** while out_valid && !out_ready, out_data, out_flag and out_valid hold stable.

## Timing
- Latency is 2 cycles from accepting handshake to out_valid, with no stall.
- Throughput is 1 word per cycle while out_ready = 1.
- Reset values: out_valid = 0, out_data = 0, out_flag = 0, stage valids = 0, stat_words = 0, stat_flags = 0. in_ready = 1 as soon as reset deasserts.
- Reset asserted mid-stream discards all in-flight words immediately (asynchronously). The first handshake after deassertion is the first word.
- in_valid may deassert at any time. in_data and in_mode are sampled only on a handshake.
- Filling with out_ready = 0: exactly 2 words are accepted, then in_ready = 0.
- When out_ready reasserts, in_ready returns to 1 in the same cycle.

## Configuration
- **MBI_STATS_EN defined:** the stat_clr, stat_words and stat_flags ports and counters exist.
  - stat_words increments on every out_valid && out_ready.
  - stat_flags increments on such a handshake when out_flag = 1.
  - Both counters saturate at 2^CNT_W − 1.
  - stat_clr has priority: a word delivered in the clear cycle is not counted.
- **MBI_STATS_EN undefined:** those ports and counters are absent. Datapath behaviour is identical.

## Structure
- Package mbi_pkg holds:
  - typedef mbi_mode_t (2-bit enum: MODE_ZMAJ, MODE_OMAJ, MODE_EVEN, MODE_ODD).
  - Function popcount width helper.
  - Constant MBI_LATENCY = 2.
- Sub-module mbi_popcount is a combinational ones-counter parameterised by DATA_W, instantiated in S1.
- All other logic lives in the top level.

## Test plan
- DATA_W=7, INS_POS=4, mode 00, in_data 7'b0000011 (ones 2) -> out_data 8'h13, out_flag 1, 2 cycles after handshake.
- Same config, mode 01, in 7'b1110111 (ones 6) -> 8'hF7. Mode 10, in 7'b0000111 -> 8'h17. Mode 11, in 7'h00 -> 8'h10.
- DATA_W=8, INS_POS=4, tie 8'h0F in modes 00 and 01 -> out_data 9'h00F. INS_POS=0 with 8'h01, mode 11 -> 9'h002. INS_POS=8 with 8'h01, mode 10 -> 9'h101.
- Back-pressure: stream 10 random words with out_ready toggling at random -> output sequence matches the reference model in order; out_data is stable during every stall; exactly 2 words are accepted while out_ready is held 0.
- Reset asserted with 2 words in flight -> out_valid = 0 immediately; the next word's output appears 2 cycles after its handshake.
- MBI_STATS_EN: deliver 5 words, 3 with flag 1 -> stat_words 5, stat_flags 3. Pulse stat_clr together with a 6th delivery -> both 0. With CNT_W=2, deliver 6 words -> stat_words saturates at 3.

Source files
------------

// File: rtl/mbi_pkg.sv
// rtl/mbi_pkg.sv - shared types and constants for the majority-bit inserter
package mbi_pkg;

  typedef enum logic [1:0] {
    MODE_ZMAJ = 2'b00,
    MODE_OMAJ = 2'b01,
    MODE_EVEN = 2'b10,
    MODE_ODD  = 2'b11
  } mbi_mode_t;

  localparam int MBI_LATENCY = 2;

  // Width needed to hold a ones count of 0..data_w inclusive.
  function automatic int mbi_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/mbi_popcount.sv
// rtl/mbi_popcount.sv - combinational ones counter over a DATA_W-bit word
module mbi_popcount
  import mbi_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int ONES_W = mbi_cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [ONES_W-1:0] o_ones
);

  always_comb begin
    o_ones = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_ones = o_ones + ONES_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/majority_bit_inserter.sv
// rtl/majority_bit_inserter.sv - two-stage flag computation and insertion
// Define MBI_STATS_EN to add delivered-word and flag statistics counters.
module majority_bit_inserter
  import mbi_pkg::*;
#(
  parameter int DATA_W  = 7,
  parameter int INS_POS = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic              out_flag
`ifdef MBI_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_words,
  output logic [CNT_W-1:0]  stat_flags
`endif
);

  localparam int ONES_W = mbi_cnt_w(DATA_W);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  mbi_mode_t         r_s1_mode;
  logic [ONES_W-1:0] r_s1_ones;

  logic [ONES_W-1:0] w_ones;
  logic [ONES_W-1:0] w_zeros;
  logic              w_flag;
  logic              w_s2_load;
  logic [DATA_W:0]   w_word;

  mbi_popcount #(
    .DATA_W(DATA_W),
    .ONES_W(ONES_W)
  ) u_popcount (
    .i_data(in_data),
    .o_ones(w_ones)
  );

  // The output register may reload whenever it is empty or being drained.
  assign w_s2_load = !out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;

  always_comb begin
    w_flag  = 1'b0;
    w_zeros = ONES_W'(DATA_W) - r_s1_ones;
    unique case (r_s1_mode)
      MODE_ZMAJ: w_flag = (w_zeros > r_s1_ones);
      MODE_OMAJ: w_flag = (r_s1_ones > w_zeros);
      MODE_EVEN: w_flag = r_s1_ones[0];
      MODE_ODD:  w_flag = ~r_s1_ones[0];
    endcase
  end

  generate
    if (INS_POS == 0) begin : g_ins_lsb
      assign w_word = {r_s1_data, w_flag};
    end else if (INS_POS == DATA_W) begin : g_ins_msb
      assign w_word = {w_flag, r_s1_data};
    end else begin : g_ins_mid
      assign w_word = {r_s1_data[DATA_W-1:INS_POS], w_flag, r_s1_data[INS_POS-1:0]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= MODE_ZMAJ;
      r_s1_ones  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_flag   <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        r_s1_data <= in_data;
        r_s1_mode <= mbi_mode_t'(in_mode);
        r_s1_ones <= w_ones;
      end
      if (w_s2_load) begin
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          out_data <= w_word;
          out_flag <= w_flag;
        end
      end
    end
  end

`ifdef MBI_STATS_EN
  // Clear wins over a same-cycle delivery; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words <= '0;
      stat_flags <= '0;
    end else if (stat_clr) begin
      stat_words <= '0;
      stat_flags <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_words != '1) begin
        stat_words <= stat_words + CNT_W'(1);
      end
      if (out_flag && (stat_flags != '1)) begin
        stat_flags <= stat_flags + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_majority_bit_inserter.sv
// tb/tb_majority_bit_inserter.sv - scoreboard bench for majority_bit_inserter
module tb_majority_bit_inserter;

  typedef struct {
    logic [8:0] d;
    logic       f;
    int         acc;
    bit         strict;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_data = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_flag;

`ifdef MBI_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_words, stat_flags;
  logic        sat_ir, sat_ov, sat_of;
  logic [7:0]  sat_od;
  logic [1:0]  sat_words, sat_flags;
`endif

  majority_bit_inserter #(.DATA_W(7), .INS_POS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flag(out_flag)
`ifdef MBI_STATS_EN
    , .stat_clr(stat_clr), .stat_words(stat_words), .stat_flags(stat_flags)
`endif
  );

`ifdef MBI_STATS_EN
  majority_bit_inserter #(.DATA_W(7), .INS_POS(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(sat_ir), .in_data(in_data), .in_mode(in_mode),
    .out_valid(sat_ov), .out_ready(1'b1), .out_data(sat_od), .out_flag(sat_of),
    .stat_clr(stat_clr), .stat_words(sat_words), .stat_flags(sat_flags)
  );
`endif

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: flag from counted ones/zeros, word built by shift-and-or.
  function automatic logic [64:0] model(input logic [63:0] d, input int dw, input int ip,
                                        input logic [1:0] m, output logic f);
    int ones;
    int zeros;
    logic [64:0] dd;
    logic [64:0] lo;
    logic [64:0] hi;
    ones  = $countones(d);
    zeros = dw - ones;
    case (m)
      2'd0:    f = (zeros > ones);
      2'd1:    f = (ones > zeros);
      2'd2:    f = ((ones % 2) == 1);
      default: f = ((ones % 2) == 0);
    endcase
    dd = {1'b0, d};
    lo = dd & ((65'd1 << ip) - 65'd1);
    hi = (dd >> ip) << (ip + 1);
    return hi | lo | ({64'd0, f} << ip);
  endfunction

  function automatic logic [8:0] side_const(input int g, input int k);
    case (g)
      0:       return (k < 2) ? 9'h00F : (k == 2) ? 9'h001 : 9'h011;
      1:       return (k < 2) ? 9'h01E : (k == 2) ? 9'h002 : 9'h003;
      default: return (k < 2) ? 9'h00F : (k == 2) ? 9'h001 : 9'h101;
    endcase
  endfunction

  exp_t q[$];

  task automatic push_main(input logic [6:0] d, input logic [1:0] m, input bit strict,
                           input bit use_c, input logic [7:0] cd, input logic cf);
    exp_t e;
    logic f;
    logic [64:0] w;
    w = model({57'd0, d}, 7, 4, m, f);
    e.d      = use_c ? {1'b0, cd} : w[8:0];
    e.f      = use_c ? cf : f;
    e.acc    = cyc;
    e.strict = strict;
    q.push_back(e);
  endtask

  task automatic send(input logic [6:0] d, input logic [1:0] m, input bit strict, input bit rnd,
                      input bit use_c, input logic [7:0] cd, input logic cf);
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        push_main(d, m, strict, use_c, cd, cf);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 50 && q.size() > 0; n++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  bit         prev_stall = 0;
  bit         seen = 0;
  int         first_cyc = 0;
  logic [7:0] prev_d;
  logic       prev_f;
  exp_t       me;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      seen       = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_flag", out_flag, prev_f);
      end
      if (out_valid && !seen) begin
        seen      = 1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          me = q.pop_front();
          chk("out_data", out_data, me.d);
          chk("out_flag", out_flag, me.f);
          if (me.strict) chk("latency", first_cyc - me.acc, 2);
          else           chk("latency_min", (first_cyc - me.acc) >= 2, 1);
        end
        seen = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_f     = out_flag;
    end
  end

  logic       side_valid = 1'b0;
  logic [7:0] side_data = '0;
  logic [1:0] side_mode = '0;
  int         side_idx = -1;

  for (genvar g = 0; g < 3; g++) begin : g_side
    localparam int IP = (g == 0) ? 4 : (g == 1) ? 0 : 8;
    logic        s_ir, s_ov, s_of;
    logic [8:0]  s_od;
    exp_t        sq[$];
    exp_t        se;
    logic        sf;
    logic [64:0] sw;
`ifdef MBI_STATS_EN
    logic [15:0] s_sw, s_sf;
`endif

    majority_bit_inserter #(.DATA_W(8), .INS_POS(IP), .CNT_W(16)) u_side (
      .clk(clk), .rst(rst),
      .in_valid(side_valid), .in_ready(s_ir), .in_data(side_data), .in_mode(side_mode),
      .out_valid(s_ov), .out_ready(1'b1), .out_data(s_od), .out_flag(s_of)
`ifdef MBI_STATS_EN
      , .stat_clr(stat_clr), .stat_words(s_sw), .stat_flags(s_sf)
`endif
    );

    always @(negedge clk) begin
      if (rst) begin
        sq.delete();
      end else begin
        if (side_valid && s_ir) begin
          sw       = model({56'd0, side_data}, 8, IP, side_mode, sf);
          se.d     = (side_idx >= 0) ? side_const(g, side_idx) : sw[8:0];
          se.f     = sf;
          se.acc   = cyc;
          se.strict = 1;
          sq.push_back(se);
        end
        if (s_ov) begin
          if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL side%0d_unexpected actual=%0h required=none", g, s_od);
          end else begin
            se = sq.pop_front();
            chk($sformatf("side%0d_data", g), s_od, se.d);
            chk($sformatf("side%0d_flag", g), s_of, se.f);
            chk($sformatf("side%0d_latency", g), cyc - se.acc, 2);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int nacc;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_flag", out_flag, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);

    // Directed words at DATA_W=7, INS_POS=4.
    send(7'b0000011, 2'b00, 1, 0, 1, 8'h13, 1'b1);
    send(7'b1110111, 2'b01, 1, 0, 1, 8'hF7, 1'b1);
    send(7'b0000111, 2'b10, 1, 0, 1, 8'h17, 1'b1);
    send(7'h00,      2'b11, 1, 0, 1, 8'h10, 1'b1);
    drain();

    // DATA_W=8 instances: tie, LSB and MSB insertion, then random words.
    for (int k = 0; k < 24; k++) begin
      side_valid = 1'b1;
      side_idx   = (k < 4) ? k : -1;
      case (k)
        0:       begin side_data = 8'h0F; side_mode = 2'b00; end
        1:       begin side_data = 8'h0F; side_mode = 2'b01; end
        2:       begin side_data = 8'h01; side_mode = 2'b11; end
        3:       begin side_data = 8'h01; side_mode = 2'b10; end
        default: begin side_data = 8'($urandom); side_mode = 2'($urandom); end
      endcase
      @(posedge clk);
      #1;
    end
    side_valid = 1'b0;
    side_idx   = -1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    // Random stream with random back-pressure and idle gaps.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      send(7'($urandom), 2'($urandom), 0, 1, 0, 8'h00, 1'b0);
    end
    drain();

    // Fill with the sink blocked: exactly two words fit.
    out_ready = 1'b0;
    nacc = 0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      in_data  = 7'($urandom);
      in_mode  = 2'($urandom);
      @(negedge clk);
      if (in_ready) begin
        push_main(in_data, in_mode, 0, 0, 8'h00, 1'b0);
        nacc++;
      end
      @(posedge clk);
      #1;
    end
    chk("fill_accepted", nacc, 2);
    chk("fill_in_ready_low", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_reassert", in_ready, 1);
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(7'h2A, 2'b01, 0, 0, 0, 8'h00, 1'b0);
    send(7'h15, 2'b10, 0, 0, 0, 8'h00, 1'b0);
    chk("inflight_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(7'h00, 2'b00, 1, 0, 1, 8'h10, 1'b1);
    drain();

`ifdef MBI_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("stat_words_reset", stat_words, 0);
    chk("stat_flags_reset", stat_flags, 0);
    send(7'h00, 2'b00, 0, 0, 0, 8'h00, 1'b0);
    send(7'h7F, 2'b00, 0, 0, 0, 8'h00, 1'b0);
    send(7'h01, 2'b00, 0, 0, 0, 8'h00, 1'b0);
    send(7'h7E, 2'b00, 0, 0, 0, 8'h00, 1'b0);
    send(7'h03, 2'b00, 0, 0, 0, 8'h00, 1'b0);
    drain();
    chk("stat_words_5", stat_words, 5);
    chk("stat_flags_3", stat_flags, 3);
    send(7'h05, 2'b00, 0, 0, 0, 8'h00, 1'b0);
    for (int n = 0; n < 10 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    chk("stat_words_clr", stat_words, 0);
    chk("stat_flags_clr", stat_flags, 0);
    for (int k = 0; k < 6; k++) send(7'($urandom), 2'($urandom), 0, 0, 0, 8'h00, 1'b0);
    drain();
    chk("stat_words_6", stat_words, 6);
    chk("sat_words_3", sat_words, 3);
`endif

    chk("main_q_empty", q.size(), 0);
    chk("side0_q_empty", g_side[0].sq.size(), 0);
    chk("side1_q_empty", g_side[1].sq.size(), 0);
    chk("side2_q_empty", g_side[2].sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
